divide_strobe_monitor: RTL and testbench

Receive-side checker for the divided-clock strobe produced by the divide-by-N state machine. Samples a periodic one-cycle-high strobe on the same clock, measures the cycle count between rising edges, and declares lock once consecutive periods match the expected ratio. It flags short, long, and missing pulses for board-level debug. Sits next to the divider on the Basys3 fabric; outputs drive LEDs and the debug display.

---
 rtl/strobe_mon_pkg.sv | 15 +
 rtl/divide_strobe_monitor_rise_detect.sv | 21 ++
 rtl/divide_strobe_monitor.sv | 110 +++++++++++
 tb/tb_divide_strobe_monitor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/strobe_mon_pkg.sv
// Shared types and default parameters for the divided-strobe monitor.
// No latency or flow control: declarations only.
package strobe_mon_pkg;

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    TRACK      = 2'd1,
    LOCKED     = 2'd2
  } mon_state_t;

  localparam int DEF_EXP_PERIOD = 4;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_LOCK_N     = 3;

endpackage

// File: rtl/divide_strobe_monitor_rise_detect.sv
// Rising-edge detector: combinational rise from a one-register history of y.
// No backpressure; the reset value of the history register is a parameter.
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic y,
  output logic rise
);

  logic y_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) y_q <= RESET_VAL;
    else       y_q <= y;
  end

  assign rise = y & ~y_q;

endmodule

// File: rtl/divide_strobe_monitor.sv
// Measures strobe period, tracks lock at EXP_PERIOD, flags short/long/missing pulses.
// All outputs registered one cycle after the edge cycle; y is sampled every cycle, no backpressure.
module divide_strobe_monitor
  import strobe_mon_pkg::*;
#(
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LOCK_N     = DEF_LOCK_N
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y,
  input  logic             clear_err,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err_short,
  output logic             err_long
);

  localparam int MW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [MW-1:0]    LOCK_C  = MW'(LOCK_N);

  mon_state_t       state;
  mon_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [MW-1:0]    match_cnt;
  logic [MW-1:0]    match_nxt;
  logic             edge_det;
  logic             upd_period;
  logic             set_short;
  logic             set_long;

  // y_q resets high so a strobe held high through reset is not taken as an edge.
  rise_detect #(.RESET_VAL(1'b1)) u_rise (
    .clk   (clk),
    .reset (reset),
    .y     (y),
    .rise  (edge_det)
  );

  always_comb begin
    state_nxt  = state;
    match_nxt  = match_cnt;
    upd_period = 1'b0;
    set_short  = 1'b0;
    set_long   = 1'b0;
    case (state)
      WAIT_FIRST: begin
        if (edge_det) begin
          state_nxt = TRACK;
          match_nxt = '0;
        end
      end
      TRACK, LOCKED: begin
        if (edge_det) begin
          upd_period = 1'b1;
          if (cnt == EXP_C) begin
            if (match_cnt != LOCK_C) match_nxt = match_cnt + MW'(1);
            if (match_nxt == LOCK_C) state_nxt = LOCKED;
          end else if (cnt < EXP_C) begin
            set_short = 1'b1;
            match_nxt = '0;
            state_nxt = TRACK;
          end else begin
            set_long  = 1'b1;
            match_nxt = '0;
            state_nxt = TRACK;
          end
        end else if (state == LOCKED && cnt == EXP_C) begin
          // The edge due this cycle never came.
          set_long  = 1'b1;
          match_nxt = '0;
          state_nxt = TRACK;
        end
      end
      default: begin
        state_nxt = WAIT_FIRST;
        match_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WAIT_FIRST;
      cnt          <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
    end else begin
      state     <= state_nxt;
      match_cnt <= match_nxt;
      if (edge_det)            cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
      period_valid <= upd_period;
      if (upd_period) period <= cnt;
      // A new error event outranks a simultaneous clear.
      err_short <= set_short | (err_short & ~clear_err);
      err_long  <= set_long  | (err_long  & ~clear_err);
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_divide_strobe_monitor.sv
// Scoreboarded bench: strobe stimulus feeds a timestamp-based reference model and a period queue.
// A negedge monitor compares flags every cycle and pops the queue on each period_valid.
module tb_divide_strobe_monitor;

  localparam int EXP   = 4;
  localparam int CW    = 8;
  localparam int LOCKN = 3;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk = 1'b1;
  logic          reset = 1'b1;
  logic          y = 1'b1;
  logic          clear_err = 1'b0;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          locked;
  logic          err_short;
  logic          err_long;

  divide_strobe_monitor #(.EXP_PERIOD(EXP), .CNT_W(CW), .LOCK_N(LOCKN)) dut (
    .clk          (clk),
    .reset        (reset),
    .y            (y),
    .clear_err    (clear_err),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .err_short    (err_short),
    .err_long     (err_long)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // reference model: edge timestamps rather than a cycle counter
  int   cyc = 0;
  int   m_last = 0;
  bit   m_started = 0;
  int   m_matches = 0;
  bit   m_locked = 0, m_es = 0, m_el = 0, m_pv = 0;
  logic m_yprev = 1'b1;
  bit   cur_locked = 0, cur_es = 0, cur_el = 0, cur_pv = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s act=%0d req=%0d t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("locked", int'(locked), int'(cur_locked));
      chk("err_short", int'(err_short), int'(cur_es));
      chk("err_long", int'(err_long), int'(cur_el));
      chk("period_valid", int'(period_valid), int'(cur_pv));
      if (period_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL period_unexpected act=%0d req=none t=%0t", period, $time);
        end else begin
          chk("period", int'(period), exp_q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic yv, input logic cv);
    int  per;
    bit  set_s, set_l;
    @(posedge clk);
    #1;
    cur_locked = m_locked;
    cur_es     = m_es;
    cur_el     = m_el;
    cur_pv     = m_pv;
    mon_en     = 1;
    y          = yv;
    clear_err  = cv;
    cyc++;
    m_pv  = 0;
    set_s = 0;
    set_l = 0;
    if (yv && !m_yprev) begin
      if (m_started) begin
        per = cyc - m_last;
        if (per > SAT) per = SAT;
        m_pv = 1;
        exp_q.push_back(per);
        if (per == EXP) begin
          if (m_matches < LOCKN) m_matches++;
          if (m_matches == LOCKN) m_locked = 1;
        end else begin
          if (per < EXP) set_s = 1;
          else           set_l = 1;
          m_matches = 0;
          m_locked  = 0;
        end
      end
      m_started = 1;
      m_last    = cyc;
    end else if (m_locked && (cyc - m_last) == EXP) begin
      set_l     = 1;
      m_locked  = 0;
      m_matches = 0;
    end
    m_es    = (cv ? 1'b0 : m_es) | set_s;
    m_el    = (cv ? 1'b0 : m_el) | set_l;
    m_yprev = yv;
  endtask

  task automatic pulse(input int p);
    step(1'b1, 1'b0);
    for (int i = 1; i < p; i++) step(1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_period_valid"}, int'(period_valid), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err_short"}, int'(err_short), 0);
    chk({tag, "_err_long"}, int'(err_long), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    chk("locked_pre_reset", int'(locked), int'(m_locked));
    mon_en    = 0;
    reset     = 1'b1;
    y         = 1'b1;
    clear_err = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clk);
    #3;
    reset = 1'b0;
    exp_q.delete();
    m_yprev = 1'b1; m_started = 0; m_matches = 0;
    m_locked = 0; m_es = 0; m_el = 0; m_pv = 0;
    cur_locked = 0; cur_es = 0; cur_el = 0; cur_pv = 0;
  endtask

  initial begin
    #12;
    check_zero("reset");
    #3;
    reset = 1'b0;

    // strobe held high through reset must not count as an edge
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    repeat (8) pulse(4);

    // short period then re-lock
    pulse(3);
    repeat (5) pulse(4);

    // missing pulse while locked: 8-cycle period
    pulse(8);
    repeat (5) pulse(4);

    // counter saturation
    pulse(301);
    repeat (5) pulse(4);

    // clear coincident with a short-period edge, then clear alone
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    repeat (4) pulse(4);

    // randomized periods, pulse widths and clears
    for (int n = 0; n < 150; n++) begin
      int p, w;
      p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 9)) : EXP;
      w = int'($urandom_range(1, p - 1));
      for (int i = 0; i < p; i++)
        step((i < w) ? 1'b1 : 1'b0, ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
    end

    // asynchronous reset while locked, then re-lock
    repeat (5) pulse(4);
    do_reset();
    repeat (6) pulse(4);
    repeat (10) step(1'b0, 1'b0);

    @(negedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
